// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store memory access controller.
//   WORD_BYTES : bytes per memory word (little-endian 64-bit word)
//   ADDR_W     : request/memory address width
//   DATA_W     : data word width
//   state_t    : controller FSM states
//   status_t   : response status codes (OK / ADR / MIS)
package mem_access_pkg;

  localparam int WORD_BYTES = 8;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK  = 2'd0,
    STAT_ADR = 2'd1,
    STAT_MIS = 2'd2
  } status_t;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address qualification for one 8-byte access.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (adds misalignment check).
// Ports:
//   address : byte address of the requested 8-byte word
//   status  : STAT_OK, STAT_ADR (word would run past memory end) or
//             STAT_MIS (not 8-byte aligned, only with the macro defined)
module mem_addr_check
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic [ADDR_W-1:0] address,
  output status_t           status
);

  // Highest address at which a whole word still fits. Unsigned 64-bit
  // compare, so addresses close to 2^64 can never wrap into range.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  always_comb begin
    status = STAT_OK;
    if (address > LAST_WORD) begin
      status = STAT_ADR;
    end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    else if (address[2:0] != 3'b000) begin
      status = STAT_MIS;
    end
`endif
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a data memory with
// combinational read and posedge write.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (reject misaligned words).
// Ports:
//   clock, reset            : sole clock, asynchronous active-high reset
//   reqValid/reqReady       : request handshake (ready only in IDLE)
//   reqWrite, reqAddress,
//   reqData                 : request kind, byte address, store data
//   memAddress, memWriteData,
//   memWrite, memRead       : registered memory strobes, live only in ACCESS
//   memReadData             : memory read data (combinational)
//   respValid/respReady     : response handshake (valid only in RESP)
//   respData, respStatus    : load data (0 otherwise) and status code
//   adrErrCount             : saturating count of non-OK responses
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqValid,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddress,
  input  logic [DATA_W-1:0] reqData,
  output logic              reqReady,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] memReadData,
  output logic              respValid,
  output logic [DATA_W-1:0] respData,
  output logic [1:0]        respStatus,
  input  logic              respReady,
  output logic [7:0]        adrErrCount
);

  state_t  state;
  state_t  state_next;
  status_t chk_status;

  logic accept_ok;
  logic accept_err;
  logic access_end;
  logic resp_done;

  mem_addr_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_addr_check (
    .address(reqAddress),
    .status (chk_status)
  );

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (reqValid) begin
          state_next = (chk_status == STAT_OK) ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP: begin
        if (respReady) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // reqValid is only looked at in IDLE and respReady only in RESP.
  always_comb begin
    reqReady   = (state == ST_IDLE);
    accept_ok  = reqReady && reqValid && (chk_status == STAT_OK);
    accept_err = reqReady && reqValid && (chk_status != STAT_OK);
    access_end = (state == ST_ACCESS);
    resp_done  = (state == ST_RESP) && respReady;
  end

  // Stage 1: memory strobes, set on acceptance and live for exactly the
  // ACCESS cycle. Async reset drops a pending store before its write edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memAddress   <= '0;
      memWriteData <= '0;
      memWrite     <= 1'b0;
      memRead      <= 1'b0;
    end else if (accept_ok) begin
      memAddress   <= reqAddress;
      memWriteData <= reqData;
      memWrite     <= reqWrite;
      memRead      <= !reqWrite;
    end else begin
      memAddress   <= '0;
      memWriteData <= '0;
      memWrite     <= 1'b0;
      memRead      <= 1'b0;
    end
  end

  // Stage 2: response register, loaded on entry to RESP and held until the
  // consumer takes it. memRead still identifies a load on the ACCESS edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      respValid  <= 1'b0;
      respData   <= '0;
      respStatus <= STAT_OK;
    end else if (accept_err) begin
      respValid  <= 1'b1;
      respData   <= '0;
      respStatus <= chk_status;
    end else if (access_end) begin
      respValid  <= 1'b1;
      respData   <= memRead ? memReadData : '0;
      respStatus <= STAT_OK;
    end else if (resp_done) begin
      respValid  <= 1'b0;
      respData   <= '0;
      respStatus <= STAT_OK;
    end
  end

  // Only rejected requests enter RESP with a non-zero status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      adrErrCount <= 8'd0;
    end else if (accept_err) begin
      adrErrCount <= sat_inc8(adrErrCount);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int MEM_BYTES = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [63:0] reqAddress = '0;
  logic [63:0] reqData = '0;
  logic        reqReady;
  logic [63:0] memAddress;
  logic [63:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [63:0] memReadData;
  logic        respValid;
  logic [63:0] respData;
  logic [1:0]  respStatus;
  logic        respReady = 1'b1;
  logic [7:0]  adrErrCount;

  int errors = 0;
  int checks = 0;
  logic [65:0] exp_q[$];

  bit [7:0] mem [0:MEM_BYTES-1];

  always #5 clock = ~clock;

  mem_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqWrite    (reqWrite),
    .reqAddress  (reqAddress),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .memReadData (memReadData),
    .respValid   (respValid),
    .respData    (respData),
    .respStatus  (respStatus),
    .respReady   (respReady),
    .adrErrCount (adrErrCount)
  );

  // Data memory model: little-endian, combinational read, posedge write.
  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[(a + i) % MEM_BYTES];
    return r;
  endfunction

  always_comb memReadData = memRead ? mem_word(int'(memAddress[6:0])) : 64'd0;

  always @(posedge clock) begin
    if (memWrite) begin
      for (int i = 0; i < 8; i++)
        mem[(int'(memAddress[6:0]) + i) % MEM_BYTES] <= memWriteData[8*i +: 8];
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares each response at its handshake.
  initial begin
    logic [65:0] e;
    forever begin
      @(negedge clock);
      if (!reset && respValid && respReady) begin
        if (exp_q.size() == 0) begin
          check64("unexpected_response", {62'd0, respStatus}, 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check64("resp_data", respData, e[65:2]);
          check64("resp_status", {62'd0, respStatus}, {62'd0, e[1:0]});
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                       input logic [63:0] exp_data, input logic [1:0] exp_stat);
    int n;
    int exp_lat;
    exp_lat = (exp_stat == 2'd0) ? 2 : 1;
    @(negedge clock);
    reqValid = 1'b1; reqWrite = wr; reqAddress = addr; reqData = data;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    check64("req_ready_wait", {63'd0, reqReady}, 64'd1);
    if (!reqReady) begin
      reqValid = 1'b0;
      return;
    end
    @(posedge clock);
    exp_q.push_back({exp_data, exp_stat});
    #1;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqData = '0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        check64("access_mem_write", {63'd0, memWrite}, {63'd0, (exp_lat == 2) && wr});
        check64("access_mem_read", {63'd0, memRead}, {63'd0, (exp_lat == 2) && !wr});
        check64("access_mem_addr", memAddress, (exp_lat == 2) ? addr : 64'd0);
        check64("access_mem_wdata", memWriteData, (exp_lat == 2) ? data : 64'd0);
      end
    end while (!respValid && n < 20);
    check64("resp_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_reqReady"}, {63'd0, reqReady}, 64'd1);
    check64({tag, "_memWrite"}, {63'd0, memWrite}, 64'd0);
    check64({tag, "_memRead"}, {63'd0, memRead}, 64'd0);
    check64({tag, "_memAddress"}, memAddress, 64'd0);
    check64({tag, "_memWriteData"}, memWriteData, 64'd0);
    check64({tag, "_respValid"}, {63'd0, respValid}, 64'd0);
    check64({tag, "_respData"}, respData, 64'd0);
    check64({tag, "_respStatus"}, {62'd0, respStatus}, 64'd0);
    check64({tag, "_adrErrCount"}, {56'd0, adrErrCount}, 64'd0);
  endtask

  initial begin
    int n;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Store then load back at 0x10.
    issue(1'b1, 64'h10, 64'h1122334455667788, 64'd0, 2'd0);
    issue(1'b0, 64'h10, 64'd0, 64'h1122334455667788, 2'd0);

    // Last in-range word, then one byte past it.
    issue(1'b1, 64'd120, 64'h0102030405060708, 64'd0, 2'd0);
    issue(1'b0, 64'd120, 64'd0, 64'h0102030405060708, 2'd0);
    issue(1'b0, 64'd121, 64'd0, 64'd0, 2'd1);
    check64("adr_count_after_121", {56'd0, adrErrCount}, 64'd1);

    // Address near 2^64 must not wrap into range.
    issue(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 2'd1);
    check64("adr_count_after_wrap", {56'd0, adrErrCount}, 64'd2);

    // Back-pressure: response held for 5 cycles.
    @(posedge clock); #1 respReady = 1'b0;
    issue(1'b0, 64'h10, 64'd0, 64'h1122334455667788, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check64("hold_respValid", {63'd0, respValid}, 64'd1);
      check64("hold_respData", respData, 64'h1122334455667788);
      check64("hold_respStatus", {62'd0, respStatus}, 64'd0);
      check64("hold_reqReady", {63'd0, reqReady}, 64'd0);
    end
    @(posedge clock); #1 respReady = 1'b1;

    // Reset in the middle of a store's ACCESS cycle.
    issue(1'b1, 64'h20, 64'hAAAABBBBCCCCDDDD, 64'd0, 2'd0);
    issue(1'b0, 64'h20, 64'd0, 64'hAAAABBBBCCCCDDDD, 2'd0);
    @(negedge clock);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 64'h20; reqData = 64'h1234567890ABCDEF;
    @(posedge clock); #1;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqData = '0;
    check64("pre_reset_memWrite", {63'd0, memWrite}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("midaccess");
    @(negedge clock);
    reset = 1'b0;
    issue(1'b0, 64'h20, 64'd0, 64'hAAAABBBBCCCCDDDD, 2'd0);

    // Misaligned store at 0x13.
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    issue(1'b1, 64'h13, 64'hCAFEF00D12345678, 64'd0, 2'd2);
    @(negedge clock);
    check64("mis_count", {56'd0, adrErrCount}, 64'd1);
    check64("mis_mem_unchanged", mem_word(19), 64'h0000001122334455);
`else
    issue(1'b1, 64'h13, 64'hCAFEF00D12345678, 64'd0, 2'd0);
    @(negedge clock);
    check64("mis_count", {56'd0, adrErrCount}, 64'd0);
    check64("mis_mem_written", mem_word(19), 64'hCAFEF00D12345678);
    issue(1'b0, 64'h13, 64'd0, 64'hCAFEF00D12345678, 2'd0);
`endif

    // Error counter saturates at 255.
    for (int i = 0; i < 260; i++) issue(1'b0, 64'h100, 64'd0, 64'd0, 2'd1);
    @(negedge clock);
    check64("adr_count_saturated", {56'd0, adrErrCount}, 64'd255);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
